led_fader: RTL and testbench

Output stage between the pattern sequencer and the board LED pins. It takes each new LED pattern word the sequencer fetches and drives the pins with a PWM signal. Each LED ramps its brightness toward fully on (pattern bit 1) or fully off (pattern bit 0) instead of switching hard, so hard on/off patterns show as smooth fades. It runs on the same divided clock as the sequencer.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_fade_channel.sv | 57 +++++
 rtl/led_fader.sv | 75 +++++++
 tb/tb_led_fader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared defaults and the per-channel fade state for the LED output stage.
package led_pkg;

  localparam int DEF_NLEDS    = 5;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_PWM_MAX  = (1 << DEF_PWM_BITS) - 1;

  // Per-channel state. It is derived from level and target and is not stored.
  typedef enum logic [1:0] {
    OFF,
    RISING,
    ON,
    FALLING
  } ch_state_e;

  // Classifies a channel from its target bit and whether its level sits at 0 or at full scale.
  function automatic ch_state_e ch_state(input logic target, input logic at_min, input logic at_max);
    if (target) return at_max ? ON : RISING;
    else        return at_min ? OFF : FALLING;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel. It holds a brightness level, steps it toward the target endpoint on
// each fade tick with saturation, and drives a registered PWM bit from it.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                target,
  output logic                led,
  output logic                at_end
);

  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(FADE_STEP);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS:0]   sum;
  ch_state_e           state;

  // Saturating step toward the target endpoint. The add carries one extra bit so it cannot wrap.
  always_comb begin
    sum       = {1'b0, level} + STEP;
    level_nxt = level;
    if (target) level_nxt = (sum > {1'b0, LMAX}) ? LMAX : sum[PWM_BITS-1:0];
    else        level_nxt = ({1'b0, level} < STEP) ? '0 : level - STEP[PWM_BITS-1:0];
  end

  // Endpoint flag and debug state, both derived from the current level.
  always_comb begin
    at_end = target ? (level == LMAX) : (level == '0);
    state  = ch_state(target, level == '0, level == LMAX);
  end

  // Level advances only on fade ticks. The PWM bit is registered.
  // Full scale forces a true 100% duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (fade_tick) level <= level_nxt;
      led <= (level == LMAX) | (pwm_cnt < level);
    end
  end

  a_on_holds: assert property (@(posedge clk) disable iff (rst)
    (fade_tick && state == ON) |=> (level == LMAX));
  a_off_holds: assert property (@(posedge clk) disable iff (rst)
    (fade_tick && state == OFF) |=> (level == '0));

endmodule

// File: rtl/led_fader.sv
// LED output stage. It latches pattern words from the sequencer and fades each LED toward
// its pattern bit. The fade timebase and the shared PWM counter live here.
module led_fader
  import led_pkg::*;
#(
  parameter int NLEDS     = DEF_NLEDS,
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int FADE_DIV  = 1024,
  parameter int FADE_STEP = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NLEDS-1:0] pattern,
  input  logic             pattern_valid,
  output logic [NLEDS-1:0] LEDS,
  output logic             settled
);

  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  if (FADE_DIV < 1) begin : g_bad_div
    $error("led_fader: FADE_DIV must be at least 1");
  end
  if (FADE_STEP < 1 || FADE_STEP > (1 << PWM_BITS) - 1) begin : g_bad_step
    $error("led_fader: FADE_STEP must be in 1..2^PWM_BITS-1");
  end

  logic [NLEDS-1:0]    target;
  logic [NLEDS-1:0]    at_end;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                fade_tick;

  assign fade_tick = (div_cnt == DIV_W'(FADE_DIV - 1));

  // Target pattern. A strobe coinciding with a tick takes effect from the following tick,
  // because the channels see the old target on that edge.
  always_ff @(posedge CLK) begin
    if (RESET)              target <= '0;
    else if (pattern_valid) target <= pattern;
  end

  // Free-running PWM counter and the fade tick divider.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      div_cnt <= fade_tick ? '0 : div_cnt + 1'b1;
    end
  end

  // settled is registered, so it lags a level change by one cycle, in step with LEDS.
  always_ff @(posedge CLK) begin
    if (RESET) settled <= 1'b0;
    else       settled <= &at_end;
  end

  for (genvar i = 0; i < NLEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .clk      (CLK),
      .rst      (RESET),
      .fade_tick(fade_tick),
      .pwm_cnt  (pwm_cnt),
      .target   (target[i]),
      .led      (LEDS[i]),
      .at_end   (at_end[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader. dut uses FADE_DIV=4 and STEP=64. dut2 ticks every cycle
// with STEP=255. dut3 uses a long tick period, so a mid-scale level holds for a duty count.
module tb_led_fader;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] pattern, pattern2, pattern3;
  logic       pattern_valid, pv2, pv3;
  logic [4:0] LEDS, LEDS2, LEDS3;
  logic       settled, settled2, settled3;

  int vec = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  led_fader #(.NLEDS(5), .PWM_BITS(8), .FADE_DIV(4), .FADE_STEP(64)) dut (
    .CLK(CLK), .RESET(RESET), .pattern(pattern), .pattern_valid(pattern_valid),
    .LEDS(LEDS), .settled(settled));

  led_fader #(.NLEDS(5), .PWM_BITS(8), .FADE_DIV(1), .FADE_STEP(255)) dut2 (
    .CLK(CLK), .RESET(RESET), .pattern(pattern2), .pattern_valid(pv2),
    .LEDS(LEDS2), .settled(settled2));

  led_fader #(.NLEDS(5), .PWM_BITS(8), .FADE_DIV(1024), .FADE_STEP(128)) dut3 (
    .CLK(CLK), .RESET(RESET), .pattern(pattern3), .pattern_valid(pv3),
    .LEDS(LEDS3), .settled(settled3));

  logic [7:0] lvl  [5];
  logic [7:0] lvl2 [5];
  for (genvar g = 0; g < 5; g++) begin : g_mon
    assign lvl[g]  = dut.g_ch[g].u_ch.level;
    assign lvl2[g] = dut2.g_ch[g].u_ch.level;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Entered at a negedge. Returns at the negedge just after the next fade tick edge of dut.
  task automatic next_tick();
    int n = 0;
    while (!dut.fade_tick && n < 8) begin @(negedge CLK); n++; end
    if (!dut.fade_tick) begin
      vec++; bad++;
      $display("FAIL tick_wait: no fade_tick after %0d cycles, required within 8", n);
    end
    @(negedge CLK);
  endtask

  task automatic strobe(input logic [4:0] p);
    pattern = p; pattern_valid = 1'b1;
    @(negedge CLK);
    pattern_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    pattern = '0; pattern_valid = 1'b0;
    pattern2 = '0; pv2 = 1'b0; pattern3 = '0; pv3 = 1'b0;
    repeat (3) @(negedge CLK);
    vec++; if (LEDS !== 5'b0) begin bad++; $display("FAIL rst_leds: got %b want 00000", LEDS); end
    vec++; if (settled !== 1'b0) begin bad++; $display("FAIL rst_settled: got %b want 0", settled); end
    vec++; if (settled2 !== 1'b0) begin bad++; $display("FAIL rst_settled2: got %b want 0", settled2); end
    RESET = 1'b0;
    @(negedge CLK);
    vec++; if (settled !== 1'b1) begin bad++; $display("FAIL rel_settled: got %b want 1", settled); end
    vec++; if (settled3 !== 1'b1) begin bad++; $display("FAIL rel_settled3: got %b want 1", settled3); end
  endtask

  task automatic test_rise();
    int exp_r [4] = '{64, 128, 192, 255};
    int hi0 = 0, hio = 0;
    strobe(5'b00001);
    for (int k = 0; k < 4; k++) begin
      next_tick();
      vec++; if (lvl[0] !== 8'(exp_r[k])) begin bad++; $display("FAIL rise_lvl%0d: got %0d want %0d", k, lvl[0], exp_r[k]); end
      vec++; if (lvl[1] !== 8'd0) begin bad++; $display("FAIL rise_other%0d: got %0d want 0", k, lvl[1]); end
    end
    vec++; if (settled !== 1'b0) begin bad++; $display("FAIL rise_settled_lag: got %b want 0", settled); end
    @(negedge CLK);
    vec++; if (settled !== 1'b1) begin bad++; $display("FAIL rise_settled: got %b want 1", settled); end
    for (int c = 0; c < 256; c++) begin
      if (LEDS[0]) hi0++;
      if (LEDS[4:1] != 4'b0) hio++;
      @(negedge CLK);
    end
    vec++; if (hi0 != 256) begin bad++; $display("FAIL full_duty: got %0d high want 256", hi0); end
    vec++; if (hio != 0) begin bad++; $display("FAIL other_dark: got %0d high want 0", hio); end
  endtask

  task automatic test_fall();
    int exp_f [4] = '{191, 127, 63, 0};
    int lit = 0;
    strobe(5'b11111);
    repeat (4) next_tick();
    for (int i = 0; i < 5; i++) begin
      vec++; if (lvl[i] !== 8'd255) begin bad++; $display("FAIL allon_lvl%0d: got %0d want 255", i, lvl[i]); end
    end
    @(negedge CLK);
    vec++; if (settled !== 1'b1) begin bad++; $display("FAIL allon_settled: got %b want 1", settled); end
    strobe(5'b11111);
    next_tick();
    vec++; if (lvl[2] !== 8'd255 || settled !== 1'b1) begin
      bad++; $display("FAIL same_pattern: got lvl %0d settled %b want 255 1", lvl[2], settled); end
    strobe(5'b00000);
    for (int k = 0; k < 4; k++) begin
      next_tick();
      for (int i = 0; i < 5; i++) begin
        vec++; if (lvl[i] !== 8'(exp_f[k])) begin bad++; $display("FAIL fall_lvl%0d_%0d: got %0d want %0d", i, k, lvl[i], exp_f[k]); end
      end
    end
    @(negedge CLK);
    vec++; if (settled !== 1'b1) begin bad++; $display("FAIL fall_settled: got %b want 1", settled); end
    for (int c = 0; c < 256; c++) begin
      if (LEDS != 5'b0) lit++;
      @(negedge CLK);
    end
    vec++; if (lit != 0) begin bad++; $display("FAIL zero_duty: got %0d lit cycles want 0", lit); end
  endtask

  task automatic test_reversal();
    int n = 0;
    strobe(5'b00001);
    next_tick();
    vec++; if (lvl[0] !== 8'd64) begin bad++; $display("FAIL rev_first: got %0d want 64", lvl[0]); end
    while (!dut.fade_tick && n < 8) begin @(negedge CLK); n++; end
    strobe(5'b00000);
    vec++; if (lvl[0] !== 8'd128) begin bad++; $display("FAIL rev_collide: got %0d want 128", lvl[0]); end
    next_tick();
    vec++; if (lvl[0] !== 8'd64) begin bad++; $display("FAIL rev_down: got %0d want 64", lvl[0]); end
    next_tick();
    @(negedge CLK);
    vec++; if (lvl[0] !== 8'd0 || settled !== 1'b1) begin
      bad++; $display("FAIL rev_end: got lvl %0d settled %b want 0 1", lvl[0], settled); end
  endtask

  task automatic test_reset_mid();
    strobe(5'b00001);
    next_tick();
    next_tick();
    vec++; if (lvl[0] !== 8'd128) begin bad++; $display("FAIL mid_pre: got %0d want 128", lvl[0]); end
    RESET = 1'b1; pattern = 5'b11111; pattern_valid = 1'b1;
    @(negedge CLK);
    vec++; if (lvl[0] !== 8'd0) begin bad++; $display("FAIL mid_lvl: got %0d want 0", lvl[0]); end
    vec++; if (LEDS !== 5'b0 || settled !== 1'b0) begin
      bad++; $display("FAIL mid_out: got leds %b settled %b want 00000 0", LEDS, settled); end
    vec++; if (dut.pwm_cnt !== 8'd0) begin bad++; $display("FAIL mid_pwm: got %0d want 0", dut.pwm_cnt); end
    repeat (2) @(negedge CLK);
    RESET = 1'b0; pattern_valid = 1'b0; pattern = 5'b0;
    @(negedge CLK);
    vec++; if (settled !== 1'b1) begin bad++; $display("FAIL mid_release: got %b want 1", settled); end
    next_tick();
    vec++; if (lvl[0] !== 8'd0 || lvl[4] !== 8'd0) begin
      bad++; $display("FAIL mid_ignored: got %0d %0d want 0 0", lvl[0], lvl[4]); end
  endtask

  task automatic test_duty();
    int n = 0, hi = 0;
    pattern3 = 5'b00001; pv3 = 1'b1;
    @(negedge CLK);
    pv3 = 1'b0;
    while (!dut3.fade_tick && n < 2100) begin @(negedge CLK); n++; end
    @(negedge CLK);
    vec++; if (dut3.g_ch[0].u_ch.level !== 8'd128) begin
      bad++; $display("FAIL duty_lvl: got %0d want 128", dut3.g_ch[0].u_ch.level); end
    @(negedge CLK);
    for (int c = 0; c < 256; c++) begin
      if (LEDS3[0]) hi++;
      @(negedge CLK);
    end
    vec++; if (hi != 128) begin bad++; $display("FAIL duty_128: got %0d high want 128", hi); end
  endtask

  task automatic test_fast();
    pattern2 = 5'b11111; pv2 = 1'b1;
    @(negedge CLK);
    pv2 = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      vec++; if (lvl2[i] !== 8'd255) begin bad++; $display("FAIL fast_lvl%0d: got %0d want 255", i, lvl2[i]); end
    end
    vec++; if (settled2 !== 1'b0) begin bad++; $display("FAIL fast_settled_lag: got %b want 0", settled2); end
    @(negedge CLK);
    vec++; if (settled2 !== 1'b1 || LEDS2 !== 5'b11111) begin
      bad++; $display("FAIL fast_settled: got settled %b leds %b want 1 11111", settled2, LEDS2); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_reversal();
    test_reset_mid();
    test_duty();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
